// File: rtl/apb_pkg.sv
// apb_pkg: shared APB completer types, default widths and the register address decode
package apb_pkg;
    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

    typedef struct packed {
        logic                  legal;
        logic [APB_ADDR_W-1:0] index;
    } apb_dec_t;

    function automatic apb_dec_t apb_decode(
        input logic [APB_ADDR_W-1:0] addr,
        input logic [APB_ADDR_W-1:0] base,
        input logic [APB_ADDR_W-1:0] span
    );
        apb_dec_t              d;
        logic [APB_ADDR_W-1:0] off;
        off     = addr - base;
        d.legal = (addr >= base) && (off < span) && (addr[1:0] == 2'b00);
        d.index = off >> 2;
        return d;
    endfunction
endpackage

// File: rtl/apb_regfile.sv
// apb_regfile: DEPTH x DATA_W register array, one synchronous write port, one combinational read port
module apb_regfile
    import apb_pkg::*;
#(
    parameter int DATA_W = APB_DATA_W,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];
endmodule

// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB3 completer over a word-addressed register bank,
// with a fixed number of wait states and an error response for bad addresses.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int                DATA_W      = APB_DATA_W,
    parameter int                ADDR_W      = APB_ADDR_W,
    parameter int                DEPTH       = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_CYCLES = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR
);
    localparam int                    IDX_W     = $clog2(DEPTH);
    localparam logic [APB_ADDR_W-1:0] SPAN      = APB_ADDR_W'(DEPTH * 4);
    localparam logic [4:0]            WAIT_LAST = 5'(WAIT_CYCLES);

    apb_state_e        r_state, w_phase;
    logic [ADDR_W-1:0] r_addr, w_src_addr;
    logic              r_write, w_src_write;
    logic [DATA_W-1:0] r_wdata, r_prdata, w_rdata;
    logic [3:0]        r_cnt;
    logic              r_pready, r_pslverr;
    logic              w_setup, w_fire, w_we;
    apb_dec_t          w_rdec, w_wdec;
    logic [IDX_W-1:0]  w_ridx, w_widx;

    // w_phase is the bus phase of the current cycle; r_state remembers the previous one
    always_comb begin
        w_phase     = (r_state == IDLE)  ? ((PSELx && !PENABLE) ? SETUP : IDLE) :
                      (r_state == SETUP) ? (PSELx ? (PENABLE ? ACCESS : SETUP) : IDLE) :
                      ((PSELx && PENABLE) ? ACCESS : IDLE);
        w_setup     = w_phase == SETUP;
        w_src_addr  = w_setup ? PADDR : r_addr;
        w_src_write = w_setup ? PWRITE : r_write;
        w_rdec      = apb_decode(APB_ADDR_W'(w_src_addr), APB_ADDR_W'(BASE_ADDR), SPAN);
        w_wdec      = apb_decode(APB_ADDR_W'(r_addr), APB_ADDR_W'(BASE_ADDR), SPAN);
        w_ridx      = IDX_W'(w_rdec.index);
        w_widx      = IDX_W'(w_wdec.index);
        w_fire      = w_setup ? (WAIT_CYCLES == 0)
                              : (w_phase == ACCESS && !r_pready && ({1'b0, r_cnt} + 5'd1) == WAIT_LAST);
        w_we        = r_pready && w_phase == ACCESS && r_write && w_wdec.legal;
    end

    // Outputs are computed one edge ahead from live setup signals or captured ones
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_state <= (w_phase == ACCESS && r_pready) ? IDLE : w_phase;
            if (w_setup) begin
                r_addr  <= PADDR;
                r_write <= PWRITE;
                r_wdata <= PWDATA;
            end
            r_cnt     <= w_setup ? 4'd0 :
                         (w_phase == ACCESS && r_cnt != WAIT_LAST[3:0]) ? r_cnt + 4'd1 : r_cnt;
            r_pready  <= w_fire;
            r_pslverr <= w_fire && !w_rdec.legal;
            r_prdata  <= (w_fire && w_rdec.legal && !w_src_write) ? w_rdata : '0;
        end
    end

    apb_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_regs (
        .i_clk  (PCLK),
        .i_rst  (PRESET),
        .i_we   (w_we),
        .i_widx (w_widx),
        .i_wdata(r_wdata),
        .i_ridx (w_ridx),
        .o_rdata(w_rdata)
    );

    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;
    assign PRDATA  = r_prdata;
endmodule
